gate_sweep_checker: RTL
=======================

Name: gate_sweep_checker

Overview:
- Clocked, parametrised successor to the free-running exhaustive stimulus used for the 4-input gate labs.
- Sweeps all 2^N_IN input vectors into a combinational DUT and holds each vector for a programmable settle time.
- Samples the DUT output and compares it against a selectable reduction function (OR/AND/XOR/NOR).
- Reports error count, first failing vector and pass/done status; sits beside the DUT in lab benches or on the FPGA board.

Parameters:
- N_IN, 4, number of DUT inputs (1..16).
- SETTLE, 2, cycles each vector is driven before it is checked (>=1).
- ERR_W, 8, width of the error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep.
- mode  input  2  expected function: 00 OR, 01 AND, 10 XOR, 11 NOR; latched on accepted start.
- pattern  output  N_IN  vector driven to DUT inputs.
- dut_out  input  1  DUT response.
- busy  output  1  sweep in progress.
- done  output  1  sweep finished; held until the next accepted start.
- pass  output  1  done and err_cnt==0.
- err_cnt  output  ERR_W  mismatch count; saturates at all-ones.
- first_fail  output  N_IN  vector of the first mismatch.
- first_fail_vld  output  1  first_fail holds a valid vector.

Behaviour:
- Reset (async, any state): state=IDLE; pattern=0, busy=0, done=0, pass=0, err_cnt=0, first_fail=0, first_fail_vld=0; latched mode=00.
- FSM states:
  - IDLE: wait for start.
  - DRIVE: settle counter runs 0..SETTLE-1.
  - CHECK: one cycle.
  - DONE: sweep complete.
- Accepted start:
  - Accepted only in IDLE or DONE; start while busy is ignored with no side effects.
  - The accepting cycle latches mode, clears err_cnt/first_fail/first_fail_vld/done/pass, sets pattern=0 and busy=1, and enters DRIVE with settle count 0.
- DRIVE: pattern is held stable. After SETTLE cycles, go to CHECK.
- CHECK:
  - dut_out is sampled on this cycle's clock edge and compared with expected = f(mode, pattern).
  - On mismatch: err_cnt increments unless it is already all-ones. If first_fail_vld=0, capture first_fail=pattern and set first_fail_vld=1.
  - If pattern is the last vector of the sequence, go to DONE. Otherwise advance pattern and return to DRIVE with settle count 0.
- Total sweep length: 2^N_IN*(SETTLE+1) cycles from the first DRIVE cycle to the DONE entry.
- DONE: busy=0, done=1, pass=(err_cnt==0). pattern holds its last value.
- Expected-function rules:
  - OR = |pattern; AND = &pattern; XOR = ^pattern; NOR = ~|pattern.
  - Computed only from the registered pattern; mode changes during a sweep have no effect.
- Pattern sequencing: binary up-count 0 .. 2^N_IN-1, no wrap. The last vector is all-ones.
- Registered outputs: all outputs are registers; there are no combinational paths from inputs to outputs.
- Reset mid-sweep: the sweep is aborted, outputs return to reset values, and the next start begins a fresh sweep.

Optional Feature:
- Macro: SWEEP_GRAY_EN.
- Defined:
  - pattern = bin ^ (bin>>1), where bin is the internal binary counter; exactly one DUT input toggles per step.
  - The last vector is 1 followed by N_IN-1 zeros (4'b1000 for N_IN=4).
  - first_fail reports the Gray vector actually driven.
- Undefined: pattern is the plain binary count; no Gray logic is synthesised.
- Sweep length and all other behaviour are identical in both builds.

Test Plan:
- Correct OR DUT, N_IN=4, SETTLE=2, mode=00, start pulse -> busy for 48 cycles, then done=1, pass=1, err_cnt=0, first_fail_vld=0.
- DUT stuck-at-0, mode=00 -> err_cnt=15, first_fail=4'b0001, first_fail_vld=1, pass=0.
- OR DUT checked with mode=10 (XOR) -> err_cnt=7, first_fail=4'b0011.
- Build with ERR_W=2, stuck-at-0 DUT, mode=00 -> err_cnt saturates at 3 and does not wrap; pass=0.
- Start re-pulsed mid-sweep -> ignored, sweep still completes at cycle 48. Assert rst during cycle 20 -> all outputs 0 immediately (asynchronous). A new start gives a full 48-cycle sweep.
- SWEEP_GRAY_EN build -> successive pattern values differ in exactly one bit; final pattern=4'b1000. Correct OR DUT gives pass=1.

Source files
------------

// File: rtl/gate_sweep_checker.sv
// Exhaustive input sweeper/checker for an N_IN-input combinational gate; SETTLE+1 cycles per vector, no backpressure.
// SWEEP_GRAY_EN: drive Gray-coded vectors instead of the binary count.
module gate_sweep_checker #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  output logic [N_IN-1:0]  pattern,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [N_IN-1:0]  first_fail,
  output logic             first_fail_vld
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  state_t          state;
  logic [SW-1:0]   settle_cnt;
  logic [N_IN-1:0] bin;
  logic [N_IN-1:0] bin_nxt;
  logic [N_IN-1:0] pat_nxt;
  logic [1:0]      mode_q;
  logic            expected;
  logic            mismatch;

  assign bin_nxt = bin + 1'b1;
`ifdef SWEEP_GRAY_EN
  assign pat_nxt = bin_nxt ^ (bin_nxt >> 1);
`else
  assign pat_nxt = bin_nxt;
`endif

  // Reference is taken from the registered vector and latched mode only.
  always_comb begin
    expected = 1'b0;
    case (mode_q)
      2'b00:   expected = |pattern;
      2'b01:   expected = &pattern;
      2'b10:   expected = ^pattern;
      default: expected = ~|pattern;
    endcase
  end

  assign mismatch = (dut_out != expected);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      settle_cnt     <= '0;
      bin            <= '0;
      mode_q         <= 2'b00;
      pattern        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_fail     <= '0;
      first_fail_vld <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mode_q         <= mode;
            err_cnt        <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            pattern        <= '0;
            bin            <= '0;
            busy           <= 1'b1;
            settle_cnt     <= '0;
            state          <= DRIVE;
          end
        end
        DRIVE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (mismatch) begin
            if (err_cnt != '1) begin
              err_cnt <= err_cnt + 1'b1;
            end
            if (!first_fail_vld) begin
              first_fail     <= pattern;
              first_fail_vld <= 1'b1;
            end
          end
          // Pass must account for a mismatch on the final vector itself.
          if (&bin) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !mismatch && (err_cnt == '0);
          end else begin
            bin        <= bin_nxt;
            pattern    <= pat_nxt;
            settle_cnt <= '0;
            state      <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
